// File: rtl/tdm_demux_5ch.sv
// tdm_demux_5ch: receive-side time-division demultiplexer.
// Locks to a slot-0 sync strobe, gathers one bit per ticked slot into a
// shadow register and commits whole frames to ch_out ({e,d,c,b,a} for 5 ch).
// Optional feature macro: TDM_DEMUX_PARITY_EN adds an even-parity slot
// after the data slots; a frame only commits when its parity checks out.
module tdm_demux_5ch #(
  parameter int NUM_CH = 5,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              din,
  input  logic              sync,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_valid,
  output logic [SEL_W-1:0]  slot,
  output logic              locked,
  output logic              sync_err,
  output logic              par_err
);

`ifdef TDM_DEMUX_PARITY_EN
  // Every data bit lands in shadow; the decision happens on the parity slot.
  localparam int SH_W = NUM_CH;
  localparam logic [SEL_W-1:0] PAR_SLOT = SEL_W'(NUM_CH);
`else
  // The last data bit goes straight from din to ch_out, so shadow is one short.
  localparam int SH_W = NUM_CH - 1;
  localparam logic [SEL_W-1:0] LAST_DATA = SEL_W'(NUM_CH - 1);
`endif

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SH_W-1:0]   shadow;
  logic [SEL_W-1:0]  slot_next;
  logic              cap_en;
  logic [SEL_W-1:0]  cap_idx;
  logic              commit;
  logic              err_set;
  logic [NUM_CH-1:0] commit_data;

`ifdef TDM_DEMUX_PARITY_EN
  logic              par_fail;
  assign commit_data = shadow;
`else
  assign commit_data = {din, shadow};
  assign par_err     = 1'b0;
`endif

  assign locked = (state == LOCK);

  // Frame state register: HUNT until a sync is seen, LOCK while framing holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Slot sequencing: decides capture, commit, framing errors and the next slot.
  always_comb begin
    state_next = state;
    slot_next  = slot;
    cap_en     = 1'b0;
    cap_idx    = '0;
    commit     = 1'b0;
    err_set    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_fail   = 1'b0;
`endif
    if (tick) begin
      case (state)
        HUNT: begin
          if (sync) begin
            cap_en     = 1'b1;
            cap_idx    = '0;
            slot_next  = SEL_W'(1);
            state_next = LOCK;
          end
        end
        LOCK: begin
          if (slot == '0) begin
            if (sync) begin
              cap_en    = 1'b1;
              cap_idx   = '0;
              slot_next = SEL_W'(1);
            end else begin
              err_set    = 1'b1;
              state_next = HUNT;
              slot_next  = '0;
            end
          end else if (sync) begin
            // Early sync: drop the partial frame and restart it from slot 0.
            err_set   = 1'b1;
            cap_en    = 1'b1;
            cap_idx   = '0;
            slot_next = SEL_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
          end else if (slot == PAR_SLOT) begin
            slot_next = '0;
            if ((^shadow ^ din) == 1'b0) begin
              commit = 1'b1;
            end else begin
              par_fail = 1'b1;
            end
`else
          end else if (slot == LAST_DATA) begin
            commit    = 1'b1;
            slot_next = '0;
`endif
          end else begin
            cap_en    = 1'b1;
            cap_idx   = slot;
            slot_next = slot + SEL_W'(1);
          end
        end
        default: begin
          state_next = HUNT;
          slot_next  = '0;
        end
      endcase
    end
  end

  // Datapath: shadow capture, frame commit, status pulses and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      slot        <= '0;
      sync_err    <= 1'b0;
    end else begin
      for (int i = 0; i < SH_W; i++) begin
        if (cap_en && (cap_idx == SEL_W'(i))) begin
          shadow[i] <= din;
        end
      end
      if (commit) begin
        ch_out <= commit_data;
      end
      frame_valid <= commit;
      slot        <= slot_next;
      if (err_set) begin
        sync_err <= 1'b1;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity failure pulse, one clock after the rejected parity slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= par_fail;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_5ch.sv
// tb_tdm_demux_5ch: randomized and directed bench for tdm_demux_5ch.
// The reference model collects received bits in a queue and commits a frame
// once the queue holds a full frame; expected slot is the queue length.
module tb_tdm_demux_5ch;
  localparam int NUM_CH = 5;
  localparam int SEL_W  = 3;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL  = NUM_CH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = NUM_CH;
  localparam bit PAR = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              tick;
  logic              din;
  logic              sync;
  logic [NUM_CH-1:0] ch_out;
  logic              frame_valid;
  logic [SEL_W-1:0]  slot;
  logic              locked;
  logic              sync_err;
  logic              par_err;

  int checks = 0;
  int errors = 0;
  int dut_fv = 0;

  bit                m_locked;
  bit                m_err;
  bit                m_fv;
  bit                m_pe;
  bit                q[$];
  logic [NUM_CH-1:0] m_ch;

  tdm_demux_5ch #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .din        (din),
    .sync       (sync),
    .ch_out     (ch_out),
    .frame_valid(frame_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ch_out", 32'(ch_out), 32'(m_ch));
    checkOutput("frame_valid", 32'(frame_valid), 32'(m_fv));
    checkOutput("slot", 32'(slot), 32'(q.size()));
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("sync_err", 32'(sync_err), 32'(m_err));
    checkOutput("par_err", 32'(par_err), 32'(m_pe));
  endtask

  task automatic modelReset();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_fv     = 1'b0;
    m_pe     = 1'b0;
    m_ch     = '0;
    q.delete();
  endtask

  task automatic modelStep(input bit s, input bit d);
    logic [NUM_CH-1:0] v;
    bit                p;
    m_fv = 1'b0;
    m_pe = 1'b0;
    if (!m_locked) begin
      if (s) begin
        q.delete();
        q.push_back(d);
        m_locked = 1'b1;
      end
    end else if (q.size() == 0) begin
      if (s) begin
        q.push_back(d);
      end else begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end
    end else if (s) begin
      m_err = 1'b1;
      q.delete();
      q.push_back(d);
    end else begin
      q.push_back(d);
      if (q.size() == FL) begin
        v = '0;
        p = 1'b0;
        for (int i = 0; i < FL; i++) begin
          p = p ^ q[i];
          if (i < NUM_CH) v[i] = q[i];
        end
        if (!PAR || !p) begin
          m_ch = v;
          m_fv = 1'b1;
        end else begin
          m_pe = 1'b1;
        end
        q.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit t, input bit s, input bit d);
    tick = t;
    sync = s;
    din  = d;
    @(posedge clk);
    if (t) begin
      modelStep(s, d);
    end else begin
      m_fv = 1'b0;
      m_pe = 1'b0;
    end
    @(negedge clk);
    if (frame_valid) dut_fv++;
    checkAll();
  endtask

  task automatic sendFrame(input logic [NUM_CH-1:0] data, input int gap, input bit bad_par);
    for (int i = 0; i < NUM_CH; i++) begin
      applyStimulus(1'b1, i == 0, data[i]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (PAR) begin
      applyStimulus(1'b1, 1'b0, (^data) ^ bad_par);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic sendTail(input logic [NUM_CH-1:0] data);
    for (int i = 1; i < NUM_CH; i++) applyStimulus(1'b1, 1'b0, data[i]);
    if (PAR) applyStimulus(1'b1, 1'b0, ^data);
  endtask

  // Main sequence: directed scenarios followed by a long random run.
  initial begin
    bit t;
    bit s;
    reset = 1'b1;
    tick  = 1'b0;
    sync  = 1'b0;
    din   = 1'b0;
    modelReset();
    @(negedge clk);
    checkAll();
    reset = 1'b0;

    sendFrame(5'b01101, 0, 1'b0);
    checkOutput("first_frame", 32'(ch_out), 32'h0D);
    checkOutput("first_locked", 32'(locked), 32'h1);
    checkOutput("first_sync_err", 32'(sync_err), 32'h0);

    dut_fv = 0;
    for (int v = 0; v < 32; v++) sendFrame(5'(v), 2, 1'b0);
    checkOutput("sweep_fv_count", 32'(dut_fv), 32'd32);
    checkOutput("sweep_last", 32'(ch_out), 32'h1F);

    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_ch_out", 32'(ch_out), 32'h0);
    checkOutput("async_slot", 32'(slot), 32'h0);
    checkOutput("async_locked", 32'(locked), 32'h0);
    checkOutput("async_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    checkAll();
    reset = 1'b0;
    sendFrame(5'b10010, 0, 1'b0);
    checkOutput("relock_frame", 32'(ch_out), 32'h12);
    checkOutput("relock_sync_err", 32'(sync_err), 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("early_sync_err", 32'(sync_err), 32'h1);
    checkOutput("early_locked", 32'(locked), 32'h1);
    checkOutput("early_slot", 32'(slot), 32'h1);
    checkOutput("early_hold", 32'(ch_out), 32'h12);
    sendTail(5'b10110);
    checkOutput("early_next_frame", 32'(ch_out), 32'h16);

    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("miss_locked", 32'(locked), 32'h0);
    checkOutput("miss_hold", 32'(ch_out), 32'h16);
    sendFrame(5'b00111, 1, 1'b0);
    checkOutput("miss_relock", 32'(ch_out), 32'h07);
    checkOutput("miss_sticky", 32'(sync_err), 32'h1);

`ifdef TDM_DEMUX_PARITY_EN
    sendFrame(5'b10110, 0, 1'b0);
    checkOutput("par_ok_fv", 32'(frame_valid), 32'h1);
    checkOutput("par_ok_data", 32'(ch_out), 32'h16);
    sendFrame(5'b10110, 0, 1'b1);
    checkOutput("par_bad_pe", 32'(par_err), 32'h1);
    checkOutput("par_bad_fv", 32'(frame_valid), 32'h0);
    checkOutput("par_bad_hold", 32'(ch_out), 32'h16);
`endif

    for (int n = 0; n < 3000; n++) begin
      t = 1'($urandom_range(0, 1));
      if (!m_locked || q.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                            s = ($urandom_range(0, 24) == 0);
      applyStimulus(t, s, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_5ch.md
Name: tdm_demux_5ch

Overview:
- Receive end of the five-input select/mux path: a time-division demultiplexer.
- A serial stream carries one bit per slot: slot 0 holds channel a, slot 4 holds channel e. Slot 0 is marked by a sync strobe.
- The block locks to sync, distributes the slot bits into per-channel shadow registers, and commits a full frame to registered parallel outputs {e,d,c,b,a}.
- It drives board LEDs and feeds mux comparison logic on BASYS3.

Parameters:
- NUM_CH, 5: channels per frame (slots 0..NUM_CH-1). Legal range 2..7.
- SEL_W, 3: width of the slot counter. Must satisfy 2**SEL_W >= NUM_CH+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  slot strobe. Sampling happens only in cycles where tick=1.
- din  input  1  serial data bit for the current slot.
- sync  input  1  frame marker, valid with tick. Must be 1 on slot 0 only.
- ch_out  output  NUM_CH  last committed frame. Bit i = slot i ({e,d,c,b,a} for NUM_CH=5).
- frame_valid  output  1  one-clk pulse in the cycle after ch_out updates.
- slot  output  SEL_W  index of the next slot to be sampled.
- locked  output  1  1 while in state LOCK.
- sync_err  output  1  sticky framing error; cleared only by reset.
- par_err  output  1  one-clk pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset values (asynchronous): ch_out=0, shadow=0, frame_valid=0, slot=0, locked=0, sync_err=0, par_err=0, state=HUNT.
- All activity is gated by tick. Cycles with tick=0 hold all state, and frame_valid/par_err drop to 0.
- HUNT:
  - tick & sync: shadow[0]<=din, slot<=1, go to LOCK.
  - tick & !sync: input ignored, slot stays 0.
- LOCK, tick=1 with slot==0:
  - sync=1: shadow[0]<=din, slot<=1.
  - sync=0: sync_err<=1, go to HUNT, slot<=0, nothing captured.
- LOCK, tick=1 with 0<slot<=NUM_CH-1:
  - sync=1 (early sync): sync_err<=1, resync in place. Treat as slot 0: shadow[0]<=din, slot<=1, stay in LOCK. The partial frame is discarded and ch_out is unchanged.
  - sync=0: shadow[slot]<=din.
- Last slot (slot==NUM_CH-1), no early sync, parity disabled:
  - ch_out <= {din, shadow[NUM_CH-2:0]} in the same edge as the capture.
  - frame_valid=1 for exactly one clk in the following cycle.
  - slot wraps to 0.
- Latency: ch_out updates on the clock edge of the last-slot tick. frame_valid is high during the cycle immediately after that edge.
- Back-to-back frames: with tick held high continuously, frame_valid pulses every NUM_CH clocks.
- locked = (state==LOCK). It falls in the cycle after a missing sync.
- Reset mid-frame: the partial frame is lost and ch_out returns to 0.
- slot never exceeds NUM_CH-1, or NUM_CH with parity enabled.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - The frame gets one extra slot, index NUM_CH, carrying even parity over the NUM_CH data bits.
  - Data slots only fill shadow. The commit decision is made on the parity slot.
  - If XOR(shadow, din)==0: ch_out updates and frame_valid pulses, timed as above but relative to the parity slot.
  - Otherwise: ch_out is held and par_err pulses for one clk, with no frame_valid. sync_err is unaffected and the block stays in LOCK.
  - slot wraps after NUM_CH.
- Undefined: no parity slot, par_err is tied to 0, and the behaviour is exactly as described in Behaviour.

Test Plan:
- Reset, then tick=1 every clk. Send sync=1 on slot 0, then din sequence a..e = 1,0,1,1,0 -> ch_out=5'b01101. frame_valid pulses once, locked=1, sync_err=0.
- Sweep all 32 values of {e,d,c,b,a} in back-to-back frames with tick at 1-in-3 clocks -> each ch_out matches its vector exactly. 32 frame_valid pulses, no errors.
- After lock, drop sync on slot 0 -> sync_err=1 (sticky), locked=0, ch_out holds its previous value. The next sync relocks and later frames decode correctly.
- Assert sync at slot 2 mid-frame -> sync_err=1, locked stays 1, slot=1 next. No commit occurs for the aborted frame; the next complete frame commits.
- Assert reset asynchronously mid-frame (between clk edges) -> all outputs 0 immediately, state=HUNT. Resync with a new frame decodes correctly.
- With TDM_DEMUX_PARITY_EN defined:
  - Data 5'b10110 with parity 1 -> commit and frame_valid.
  - Same data with parity 0 -> par_err pulses, ch_out unchanged, no frame_valid.
